pwm_multichannel: RTL and testbench
===================================

PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

Interface
REQ-001 Parameter WIDTH, default 8: counter, period and per-channel duty width in bits (2..16).
REQ-002 Parameter CHANNELS, default 4: number of independent PWM outputs sharing one counter (1..16).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 en  input  1  count enable; 0 freezes counter, direction and outputs.
REQ-006 mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled only at a period boundary.
REQ-007 period  input  WIDTH  terminal count; sampled only at a period boundary.
REQ-008 load  input  1  single-cycle strobe; captures duty_in into the pending registers.
REQ-009 duty_in  input  CHANNELS*WIDTH  duty for channel i at bits [i*WIDTH +: WIDTH].
REQ-010 invert  input  CHANNELS  per-channel output polarity, applied combinationally before the output register.
REQ-011 pwm_out  output  CHANNELS  registered PWM outputs.
REQ-012 period_done  output  1  registered one-cycle pulse marking the start of each period.
REQ-013 count  output  WIDTH  current counter value.

Function
REQ-014 Boundary: an enabled cycle in which the counter is at 0 and either starts a new period or active_period == 0.
REQ-015 At a boundary, active_period <= period and active_mode <= mode; if the pending flag is set, active duty <= pending duty and the flag clears.
REQ-016 If load and a boundary coincide, active duty <= duty_in directly; the pending flag clears.
REQ-017 A load outside a boundary overwrites the pending registers and sets the pending flag; the last load before a boundary wins.
REQ-018 Edge mode: count runs 0,1,...,active_period, then wraps to 0; the period is active_period+1 cycles.
REQ-019 Center mode: count runs 0 up to active_period, then down to 1, then back to 0; the period is 2*active_period cycles. Direction flips at active_period and at 0.
REQ-020 Counter arithmetic is WIDTH-bit unsigned; period = 2^WIDTH-1 wraps to 0 with no overflow state.
REQ-021 When active_period == 0, count holds at 0, every enabled cycle is a boundary, and all pre-invert compares are forced to 0.
REQ-022 Pre-invert compare for channel i: count < active_duty[i]. duty 0 gives 0% (always 0); duty > active_period in edge mode gives 100% (always 1).
REQ-023 Latency: pwm_out[i] at cycle t+1 = compare(t) XOR invert[i](t), for every cycle with en=1.
REQ-024 period_done is 1 in the cycle after a boundary with active_period != 0, otherwise 0; its timing is aligned with pwm_out.
REQ-025 With en=0, count, direction, pwm_out and period_done hold their values (period_done is forced to 0). load and the pending registers still operate.
REQ-026 An edge-to-center mode change takes effect only at a boundary; direction restarts as up.

Reset
REQ-027 While rst=1, asynchronously: count=0, direction=up, active_period=0, active_mode=0, active and pending duty=0, pending flag=0, pwm_out=0 (invert is ignored), period_done=0.
REQ-028 Reset mid-period discards any pending load; the first enabled cycle after release is a boundary, per REQ-021.

Verification (WIDTH=8, CHANNELS=4)
REQ-029 Reset; period=9, mode=0, load duty {ch0..3}={0,3,10,5}, en=1 -> ch0 always 0, ch1 high 3 of 10, ch2 always 1, ch3 high 5 of 10; period_done every 10 cycles.
REQ-030 Center mode, period=4, duty ch1=2 -> count sequence 0,1,2,3,4,3,2,1 repeating; ch1 high 3 of every 8 cycles, symmetric about count 4.
REQ-031 Edge mode, period=9: load duty 7 at count 4 -> ch1 keeps its old duty until the next wrap, then is high 7 of 10; a second load before the wrap overrides the first.
REQ-032 Load duty 2 in the exact boundary cycle -> ch1 high for exactly 2 cycles in that same period.
REQ-033 Hold en=0 for 5 cycles mid-period -> count and pwm_out are frozen and period_done=0; then assert rst asynchronously -> pwm_out=0 and count=0 before the next clk edge.
REQ-034 period=255, duty=128, invert=4'b0010 -> count wraps 255->0; ch1 is low 128 of every 256 cycles.

Source files
------------

// File: rtl/pwm_multichannel_if.sv
// rtl/pwm_multichannel_if.sv - control and output bundle for the multichannel PWM
interface pwm_multichannel_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic                      en;
    logic                      mode;
    logic [WIDTH-1:0]          period;
    logic                      load;
    logic [CHANNELS*WIDTH-1:0] duty_in;
    logic [CHANNELS-1:0]       invert;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_done;
    logic [WIDTH-1:0]          count;

    modport master (
        output en, mode, period, load, duty_in, invert,
        input  pwm_out, period_done, count
    );

    modport slave (
        input  en, mode, period, load, duty_in, invert,
        output pwm_out, period_done, count
    );
endinterface

// File: rtl/pwm_multichannel.sv
// rtl/pwm_multichannel.sv - shared-counter PWM with edge/center alignment and period-boundary duty updates
module pwm_multichannel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input logic                 clk,
    input logic                 rst,
    pwm_multichannel_if.slave   bus
);
    localparam logic [0:0]       DIR_UP   = 1'b0;
    localparam logic [0:0]       DIR_DOWN = 1'b1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]    count_q;
    logic [0:0]          dir_q;
    logic [WIDTH-1:0]    active_period;
    logic                active_mode;
    logic [WIDTH-1:0]    active_duty  [CHANNELS];
    logic [WIDTH-1:0]    pending_duty [CHANNELS];
    logic                pending_flag;
    logic [CHANNELS-1:0] pwm_q;
    logic                period_done_q;

    logic                boundary;
    logic [WIDTH-1:0]    eff_period;
    logic                eff_mode;
    logic [0:0]          eff_dir;
    logic [WIDTH-1:0]    eff_duty [CHANNELS];
    logic [WIDTH-1:0]    count_nxt;
    logic [0:0]          dir_nxt;
    logic [CHANNELS-1:0] pwm_nxt;

    // Every period starts with the counter at 0, so an enabled zero count is always a boundary.
    assign boundary = bus.en && (count_q == '0);

    // At a boundary the newly adopted settings already govern that cycle's compare and step.
    always_comb begin
        eff_period = boundary ? bus.period : active_period;
        eff_mode   = boundary ? bus.mode : active_mode;
        eff_dir    = boundary ? DIR_UP : dir_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (boundary && bus.load)
                eff_duty[i] = bus.duty_in[i*WIDTH +: WIDTH];
            else if (boundary && pending_flag)
                eff_duty[i] = pending_duty[i];
            else
                eff_duty[i] = active_duty[i];
        end
    end

    always_comb begin
        count_nxt = count_q;
        dir_nxt   = eff_dir;
        if (eff_period == '0) begin
            count_nxt = '0;
        end else if (!eff_mode) begin
            count_nxt = (count_q == eff_period) ? '0 : count_q + ONE;
        end else if (eff_dir == DIR_UP) begin
            if (count_q == eff_period) begin
                count_nxt = count_q - ONE;
                dir_nxt   = DIR_DOWN;
            end else begin
                count_nxt = count_q + ONE;
            end
        end else begin
            count_nxt = count_q - ONE;
        end
    end

    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < CHANNELS; i++)
            pwm_nxt[i] = ((eff_period != '0) && (count_q < eff_duty[i])) ^ bus.invert[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q       <= '0;
            dir_q         <= DIR_UP;
            active_period <= '0;
            active_mode   <= 1'b0;
            pending_flag  <= 1'b0;
            pwm_q         <= '0;
            period_done_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                active_duty[i]  <= '0;
                pending_duty[i] <= '0;
            end
        end else begin
            // Loads are captured even while counting is disabled.
            if (bus.load && !boundary) begin
                pending_flag <= 1'b1;
                for (int i = 0; i < CHANNELS; i++)
                    pending_duty[i] <= bus.duty_in[i*WIDTH +: WIDTH];
            end else if (boundary) begin
                pending_flag <= 1'b0;
            end
            if (boundary) begin
                active_period <= bus.period;
                active_mode   <= bus.mode;
                for (int i = 0; i < CHANNELS; i++)
                    active_duty[i] <= eff_duty[i];
            end
            if (bus.en) begin
                count_q       <= count_nxt;
                dir_q         <= dir_nxt;
                pwm_q         <= pwm_nxt;
                period_done_q <= boundary && (eff_period != '0);
            end else begin
                period_done_q <= 1'b0;
            end
        end
    end

    assign bus.count       = count_q;
    assign bus.pwm_out     = pwm_q;
    assign bus.period_done = period_done_q;
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb/tb_pwm_multichannel.sv - directed self-checking bench for pwm_multichannel
module tb_pwm_multichannel;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   hi [4];
    int   pd_cnt;
    logic pd_first;
    logic [7:0] cnt_log [256];
    logic [3:0] pwm_log [256];
    logic [7:0] ch1_pat;

    pwm_multichannel_if #(.WIDTH(8), .CHANNELS(4)) bus ();

    pwm_multichannel #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Samples outputs on n falling edges; any pending load strobe is dropped after the first edge.
    task automatic run(input int n);
        for (int c = 0; c < 4; c++) hi[c] = 0;
        pd_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) if (bus.pwm_out[c]) hi[c]++;
            if (bus.period_done) pd_cnt++;
            if (k == 0) pd_first = bus.period_done;
            if (k < 256) begin
                cnt_log[k] = bus.count;
                pwm_log[k] = bus.pwm_out;
            end
            bus.load = 1'b0;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.mode = 1'b0;
        bus.period = 8'd0;
        bus.load = 1'b0;
        bus.duty_in = '0;
        bus.invert = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("rst_count", bus.count, 0);
        check("rst_pwm", bus.pwm_out, 0);
        check("rst_pd", bus.period_done, 0);

        // Edge mode, period 9, load coincides with the first boundary
        rst = 1'b0;
        bus.invert = 4'h0;
        bus.period = 8'd9;
        bus.duty_in = {8'd5, 8'd10, 8'd3, 8'd0};
        bus.load = 1'b1;
        bus.en = 1'b1;
        run(20);
        check("a_ch0_hi", hi[0], 0);
        check("a_ch1_hi", hi[1], 6);
        check("a_ch2_hi", hi[2], 20);
        check("a_ch3_hi", hi[3], 10);
        check("a_pd_cnt", pd_cnt, 2);
        check("a_pd_first", pd_first, 1);
        check("a_count1", cnt_log[0], 1);
        check("a_count_wrap", cnt_log[9], 0);

        // Mid-period loads: last one before the wrap wins
        run(4);
        check("b_count4", bus.count, 4);
        bus.duty_in = {8'd5, 8'd10, 8'd8, 8'd0};
        bus.load = 1'b1;
        run(2);
        bus.duty_in = {8'd5, 8'd10, 8'd7, 8'd0};
        bus.load = 1'b1;
        run(4);
        check("b_old_duty", hi[1], 0);
        check("b_count0", bus.count, 0);
        run(10);
        check("b_new_duty", hi[1], 7);
        check("b_pd", pd_cnt, 1);

        // Load exactly at the boundary applies to that period
        bus.duty_in = {8'd5, 8'd10, 8'd2, 8'd0};
        bus.load = 1'b1;
        run(10);
        check("c_ch1_hi", hi[1], 2);
        check("c_ch3_hi", hi[3], 5);

        // Freeze with en=0, then asynchronous reset
        run(3);
        check("d_count3", bus.count, 3);
        bus.en = 1'b0;
        run(5);
        check("d_frozen_count", bus.count, 3);
        check("d_frozen_pwm", bus.pwm_out, 4'hC);
        check("d_frozen_pd", pd_cnt, 0);
        check("d_frozen_ch2", hi[2], 5);
        #2 rst = 1'b1;
        #1;
        check("d_arst_pwm", bus.pwm_out, 0);
        check("d_arst_count", bus.count, 0);
        @(negedge clk);

        // Center mode, period 4
        rst = 1'b0;
        bus.en = 1'b1;
        bus.mode = 1'b1;
        bus.period = 8'd4;
        bus.duty_in = {8'd0, 8'd0, 8'd2, 8'd0};
        bus.load = 1'b1;
        run(16);
        check("e_ch1_hi", hi[1], 6);
        check("e_pd", pd_cnt, 2);
        check("e_seq0", cnt_log[0], 1);
        check("e_seq3", cnt_log[3], 4);
        check("e_seq4", cnt_log[4], 3);
        check("e_seq6", cnt_log[6], 1);
        check("e_seq7", cnt_log[7], 0);
        for (int k = 0; k < 8; k++) ch1_pat[k] = pwm_log[k][1];
        check("e_ch1_pattern", ch1_pat, 8'h83);

        // Full-range period with inverted channel 1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mode = 1'b0;
        bus.period = 8'd255;
        bus.duty_in = {8'd128, 8'd128, 8'd128, 8'd128};
        bus.invert = 4'b0010;
        bus.load = 1'b1;
        run(256);
        check("f_ch1_hi", hi[1], 128);
        check("f_ch0_hi", hi[0], 128);
        check("f_ch1_first", pwm_log[0][1], 0);
        check("f_count255", cnt_log[254], 255);
        check("f_wrap", cnt_log[255], 0);
        check("f_pd", pd_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
